resampler_poly_nch: RTL and testbench

Parametrised polyphase FIR resampler. It produces one output frame of NUM_CH samples, in time-multiplexed channel order, for each output request. The ratio is NUM_PHASE/DECIM, set by a phase accumulator that issues input pops. It sits between the per-channel ringbuf and the mixer datapath, sharing one external pipelined multiplier and one coefficient bank across all channels.

---
 rtl/resampler_poly_nch.sv | 209 ++++++++++++++++++++
 tb/tb_resampler_poly_nch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resampler_poly_nch.sv
// -----------------------------------------------------------------------------
// resampler_poly_nch
//   Polyphase FIR resampler, NUM_CH channels time-multiplexed through one
//   shared external pipelined multiplier and one coefficient bank. Each output
//   request (pop_i) produces one frame: NUM_CH samples, channel 0 first, each
//   a TAPS-long dot product of ringbuf samples against the current phase's
//   coefficients. After the frame, the phase accumulator advances by DECIM and
//   pops the ringbufs once per NUM_PHASE wrap.
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   bank_addr_o      {phase, tap} coefficient address
//   bank_data_i      coefficient, one cycle after bank_addr_o
//   mpready_i        multiplier ready; checked only before each dot product
//   mpcand_o         sample operand to the multiplier (0 when idle)
//   mplier_o         coefficient operand to the multiplier (0 when idle)
//   mprod_i          full-precision product, MULT_LATENCY after operands
//   rb_ch_o          ringbuf channel select
//   offset_o         ringbuf tap offset
//   data_i           ringbuf sample, one cycle after offset_o/rb_ch_o
//   pop_o            one-cycle pulse, advance all ringbufs by one sample
//   pop_i            request the next output frame
//   data_o, ch_o     output sample and its channel, valid with ack_o
//   ack_o            one-cycle pulse per output sample
//   busy_o           high whenever not idle
//   overrun_o        sticky: a request arrived with one already pending
// -----------------------------------------------------------------------------
module resampler_poly_nch #(
  parameter int NUM_CH         = 2,
  parameter int NUM_CH_LOG2    = 1,
  parameter int DATA_W         = 24,
  parameter int COEF_W         = 16,
  parameter int TAPS           = 32,
  parameter int TAPS_LOG2      = 5,
  parameter int NUM_PHASE      = 2,
  parameter int NUM_PHASE_LOG2 = 1,
  parameter int DECIM          = 1,
  parameter int MULT_LATENCY   = 4,
  parameter int ACC_GUARD      = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic [NUM_PHASE_LOG2+TAPS_LOG2-1:0] bank_addr_o,
  input  logic [COEF_W-1:0]                   bank_data_i,
  input  logic                                mpready_i,
  output logic [DATA_W-1:0]                   mpcand_o,
  output logic [COEF_W-1:0]                   mplier_o,
  input  logic [DATA_W+COEF_W-1:0]            mprod_i,
  output logic [NUM_CH_LOG2-1:0]              rb_ch_o,
  output logic [TAPS_LOG2-1:0]                offset_o,
  input  logic [DATA_W-1:0]                   data_i,
  output logic                                pop_o,
  input  logic                                pop_i,
  output logic [DATA_W-1:0]                   data_o,
  output logic [NUM_CH_LOG2-1:0]              ch_o,
  output logic                                ack_o,
  output logic                                busy_o,
  output logic                                overrun_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + ACC_GUARD;
  // phase + DECIM stays below 5*NUM_PHASE <= 5*2^NUM_PHASE_LOG2
  localparam int PACC_W = NUM_PHASE_LOG2 + 3;

  // Rounding constant 2^(COEF_W-2) and saturation bounds, all ACC_W wide
  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_MP, S_ISSUE, S_DRAIN, S_ROUND, S_ADVANCE
  } state_t;

  state_t                     state;
  logic [NUM_PHASE_LOG2-1:0]  phase;
  logic [PACC_W-1:0]          phase_acc;
  logic [NUM_CH_LOG2-1:0]     ch;
  logic [TAPS_LOG2-1:0]       tap;
  logic signed [ACC_W-1:0]    acc;
  logic                       pending;

  // iss_d1: ringbuf/bank data for an issued tap is on the inputs this cycle.
  // vld_pipe[0]: operands on mpcand_o/mplier_o; vld_pipe[MULT_LATENCY]:
  // matching product on mprod_i.
  logic                       iss_d1;
  logic [MULT_LATENCY:0]      vld_pipe;

  logic signed [ACC_W-1:0]    acc_rnd;
  logic signed [ACC_W-1:0]    acc_sh;
  logic [DATA_W-1:0]          rnd_sat;
  logic                       drain_done;

  assign bank_addr_o = {phase, tap};
  assign offset_o    = tap;
  assign rb_ch_o     = ch;
  assign busy_o      = (state != S_IDLE);

  // Only the final product can still be in flight; acc absorbs it on the
  // same edge that moves us into ROUND, so ROUND sees the finished sum.
  assign drain_done = ~|{iss_d1, vld_pipe[MULT_LATENCY-1:0]};

  always_comb begin
    acc_rnd = acc + RND;
    acc_sh  = acc_rnd >>> (COEF_W - 1);
    rnd_sat = acc_sh[DATA_W-1:0];
    if (acc_sh > SAT_HI)      rnd_sat = SAT_HI[DATA_W-1:0];
    else if (acc_sh < SAT_LO) rnd_sat = SAT_LO[DATA_W-1:0];
  end

  // Operand path and validity pipeline. The block never stalls: once ISSUE
  // starts, mpready_i is not consulted until the next dot product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_d1   <= 1'b0;
      vld_pipe <= '0;
      mpcand_o <= '0;
      mplier_o <= '0;
    end else begin
      iss_d1   <= (state == S_ISSUE);
      vld_pipe <= {vld_pipe[MULT_LATENCY-1:0], iss_d1};
      mpcand_o <= iss_d1 ? data_i      : '0;
      mplier_o <= iss_d1 ? bank_data_i : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      phase_acc <= '0;
      ch        <= '0;
      tap       <= '0;
      acc       <= '0;
      pending   <= 1'b0;
      overrun_o <= 1'b0;
      data_o    <= '0;
      ch_o      <= '0;
      ack_o     <= 1'b0;
      pop_o     <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      pop_o <= 1'b0;

      if (vld_pipe[MULT_LATENCY])
        acc <= acc + {{ACC_GUARD{mprod_i[PROD_W-1]}}, mprod_i};

      // One-deep request queue while busy
      if (state != S_IDLE && pop_i) begin
        if (pending) overrun_o <= 1'b1;
        else         pending   <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (pending || pop_i) begin
            state   <= S_WAIT_MP;
            ch      <= '0;
            // A fresh pop_i alongside a queued one stays queued
            pending <= pending && pop_i;
          end
        end
        S_WAIT_MP: begin
          acc <= '0;
          tap <= '0;
          if (mpready_i) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (tap == TAPS_LOG2'(TAPS - 1)) begin
            tap   <= '0;
            state <= S_DRAIN;
          end else begin
            tap <= tap + TAPS_LOG2'(1);
          end
        end
        S_DRAIN: begin
          if (drain_done) state <= S_ROUND;
        end
        S_ROUND: begin
          data_o <= rnd_sat;
          ch_o   <= ch;
          ack_o  <= 1'b1;
          if (ch != NUM_CH_LOG2'(NUM_CH - 1)) begin
            ch    <= ch + NUM_CH_LOG2'(1);
            state <= S_WAIT_MP;
          end else begin
            phase_acc <= PACC_W'(phase) + PACC_W'(DECIM);
            state     <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          // One ringbuf pop per cycle for every NUM_PHASE wrap
          if (phase_acc >= PACC_W'(NUM_PHASE)) begin
            pop_o     <= 1'b1;
            phase_acc <= phase_acc - PACC_W'(NUM_PHASE);
          end else begin
            phase <= phase_acc[NUM_PHASE_LOG2-1:0];
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resampler_poly_nch.sv
module tb_resampler_poly_nch;

  localparam int NUM_CH = 2, DATA_W = 24, COEF_W = 16, TAPS = 32;
  localparam int NUM_PHASE = 2, MULT_LATENCY = 4;
  localparam int PROD_W = DATA_W + COEF_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]        bank_addr;
  logic [COEF_W-1:0] bank_data;
  logic              mpready = 1'b1;
  logic [DATA_W-1:0] mpcand;
  logic [COEF_W-1:0] mplier;
  logic [PROD_W-1:0] mprod;
  logic [0:0]        rb_ch;
  logic [4:0]        offset;
  logic [DATA_W-1:0] rdata;
  logic              pop_o;
  logic              pop_i = 1'b0;
  logic [DATA_W-1:0] data_o;
  logic [0:0]        ch_o;
  logic              ack_o, busy_o, overrun_o;

  resampler_poly_nch dut (
    .clk(clk), .rst(rst), .bank_addr_o(bank_addr), .bank_data_i(bank_data),
    .mpready_i(mpready), .mpcand_o(mpcand), .mplier_o(mplier), .mprod_i(mprod),
    .rb_ch_o(rb_ch), .offset_o(offset), .data_i(rdata), .pop_o(pop_o),
    .pop_i(pop_i), .data_o(data_o), .ch_o(ch_o), .ack_o(ack_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  // Second instance with DECIM=3, used only for pop sequencing
  logic [5:0]        u3_addr;
  logic [DATA_W-1:0] u3_cand, u3_data;
  logic [COEF_W-1:0] u3_plier;
  logic [0:0]        u3_rbch, u3_ch;
  logic [4:0]        u3_off;
  logic              u3_pop, u3_ack, u3_busy, u3_ovr;

  resampler_poly_nch #(.DECIM(3)) u3 (
    .clk(clk), .rst(rst), .bank_addr_o(u3_addr), .bank_data_i('0),
    .mpready_i(mpready), .mpcand_o(u3_cand), .mplier_o(u3_plier), .mprod_i('0),
    .rb_ch_o(u3_rbch), .offset_o(u3_off), .data_i('0), .pop_o(u3_pop),
    .pop_i(pop_i), .data_o(u3_data), .ch_o(u3_ch), .ack_o(u3_ack),
    .busy_o(u3_busy), .overrun_o(u3_ovr)
  );

  // Coefficient bank, ringbuf and multiplier models
  logic [COEF_W-1:0] coef [NUM_PHASE*TAPS];
  logic [DATA_W-1:0] smp  [NUM_CH][TAPS];
  logic [PROD_W-1:0] mp_pipe [MULT_LATENCY];

  always @(posedge clk) begin
    bank_data <= coef[bank_addr];
    rdata     <= smp[rb_ch][offset];
    mp_pipe[0] <= PROD_W'($signed(mpcand) * $signed(mplier));
    for (int i = 1; i < MULT_LATENCY; i++) mp_pipe[i] <= mp_pipe[i-1];
  end
  assign mprod = mp_pipe[MULT_LATENCY-1];

  // Cycle counter and output monitor
  int cyc = 0;
  int pops = 0, pops3 = 0;
  logic [DATA_W-1:0] ack_d[$];
  logic [0:0]        ack_c[$];
  int                ack_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ack_o) begin
      ack_d.push_back(data_o);
      ack_c.push_back(ch_o);
      ack_t.push_back(cyc);
    end
    if (pop_o)  pops  <= pops + 1;
    if (u3_pop) pops3 <= pops3 + 1;
  end

  int checks = 0, errors = 0;

  task automatic clear_mem();
    for (int i = 0; i < NUM_PHASE*TAPS; i++) coef[i] = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int t = 0; t < TAPS; t++) smp[c][t] = '0;
  endtask

  task automatic clear_q();
    ack_d.delete(); ack_c.delete(); ack_t.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic pulse_pop(output int t_req);
    @(posedge clk); #1;
    t_req = cyc;
    pop_i = 1'b1;
    @(posedge clk); #1;
    pop_i = 1'b0;
  endtask

  // One request, then wait (bounded) for the block to go idle again
  task automatic do_frame(output int t_req);
    pulse_pop(t_req);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!busy_o) break;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, ack_o, pop_o, overrun_o, data_o, ch_o, bank_addr, mpcand, mplier} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b ack=%b pop=%b ovr=%b data=%h addr=%h cand=%h plier=%h want all 0",
               busy_o, ack_o, pop_o, overrun_o, data_o, bank_addr, mpcand, mplier);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_impulse();
    int t;
    clear_mem(); clear_q();
    smp[0][0] = 24'h100000;
    coef[0]   = 16'h4000;
    do_frame(t);
    checks++;
    if (ack_d.size() != 2) begin
      errors++; $display("FAIL impulse_ack_count got %0d want 2", ack_d.size());
    end else begin
      checks++;
      if (ack_d[0] !== 24'h080000 || ack_c[0] !== 1'b0) begin
        errors++; $display("FAIL impulse_ch0 got data=%h ch=%0d want 080000 ch 0", ack_d[0], ack_c[0]);
      end
      checks++;
      if (ack_d[1] !== 24'h000000 || ack_c[1] !== 1'b1) begin
        errors++; $display("FAIL impulse_ch1 got data=%h ch=%0d want 000000 ch 1", ack_d[1], ack_c[1]);
      end
      // Request seen at t+1, ISSUE begins at t+2, ack 39 cycles later
      checks++;
      if (ack_t[0] != t + 2 + 39) begin
        errors++; $display("FAIL impulse_latency0 got %0d want %0d", ack_t[0] - t, 41);
      end
      // ch1: WAIT_MP during the ch0 ack cycle, ISSUE next, ack 39 later
      checks++;
      if (ack_t[1] != ack_t[0] + 1 + 39) begin
        errors++; $display("FAIL impulse_latency1 got %0d want %0d", ack_t[1] - ack_t[0], 40);
      end
    end
  endtask

  task automatic test_rounding();
    int t;
    clear_mem(); clear_q();
    smp[0][0] = 24'h000001;
    smp[1][0] = 24'hFFFFFF;
    coef[0] = 16'h4000; coef[TAPS] = 16'h4000;
    do_frame(t);
    checks++;
    if (ack_d.size() != 2 || ack_d[0] !== 24'h000001) begin
      errors++; $display("FAIL round_pos got n=%0d data=%h want 000001", ack_d.size(), ack_d.size() > 0 ? ack_d[0] : 'x);
    end
    checks++;
    if (ack_d.size() != 2 || ack_d[1] !== 24'h000000) begin
      errors++; $display("FAIL round_neg got n=%0d data=%h want 000000", ack_d.size(), ack_d.size() > 1 ? ack_d[1] : 'x);
    end
  endtask

  task automatic test_saturation();
    int t;
    clear_mem(); clear_q();
    for (int i = 0; i < TAPS; i++) begin
      smp[0][i] = 24'h7FFFFF;
      smp[1][i] = 24'h800000;
      coef[i] = 16'h7FFF; coef[TAPS+i] = 16'h7FFF;
    end
    do_frame(t);
    checks++;
    if (ack_d.size() != 2 || ack_d[0] !== 24'h7FFFFF) begin
      errors++; $display("FAIL sat_pos got n=%0d data=%h want 7fffff", ack_d.size(), ack_d.size() > 0 ? ack_d[0] : 'x);
    end
    checks++;
    if (ack_d.size() != 2 || ack_d[1] !== 24'h800000) begin
      errors++; $display("FAIL sat_neg got n=%0d data=%h want 800000", ack_d.size(), ack_d.size() > 1 ? ack_d[1] : 'x);
    end
  endtask

  // Phase 0 tap0 = 0x4000 -> 0x080000, phase 1 tap0 = 0x2000 -> 0x040000
  task automatic test_phase_pop();
    int t, p0, p3;
    logic [DATA_W-1:0] exp_d [4];
    int exp_p [4];
    int exp_p3 [4];
    exp_d  = '{24'h080000, 24'h040000, 24'h080000, 24'h040000};
    exp_p  = '{0, 1, 0, 1};
    exp_p3 = '{1, 2, 1, 2};
    clear_mem();
    smp[0][0] = 24'h100000;
    coef[0] = 16'h4000; coef[TAPS] = 16'h2000;
    apply_reset();
    for (int f = 0; f < 4; f++) begin
      clear_q();
      p0 = pops; p3 = pops3;
      do_frame(t);
      checks++;
      if (ack_d.size() != 2 || ack_d[0] !== exp_d[f]) begin
        errors++; $display("FAIL phase_data frame %0d got n=%0d data=%h want %h", f, ack_d.size(), ack_d.size() > 0 ? ack_d[0] : 'x, exp_d[f]);
      end
      checks++;
      if (pops - p0 != exp_p[f]) begin
        errors++; $display("FAIL pops_decim1 frame %0d got %0d want %0d", f, pops - p0, exp_p[f]);
      end
      checks++;
      if (pops3 - p3 != exp_p3[f]) begin
        errors++; $display("FAIL pops_decim3 frame %0d got %0d want %0d", f, pops3 - p3, exp_p3[f]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, t2;
    clear_mem();
    smp[0][0] = 24'h100000;
    coef[0] = 16'h4000; coef[TAPS] = 16'h2000;
    apply_reset();
    clear_q();
    pulse_pop(t);
    repeat (12) @(posedge clk);
    pulse_pop(t2);            // during ISSUE: queued
    repeat (8) @(posedge clk);
    pulse_pop(t2);            // queue already full: dropped
    repeat (260) @(posedge clk);
    #1;
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++; $display("FAIL overrun got %b want 1", overrun_o);
    end
    checks++;
    if (ack_d.size() != 4) begin
      errors++; $display("FAIL b2b_ack_count got %0d want 4", ack_d.size());
    end else begin
      // phase 0 frame, no pop: ADVANCE, IDLE, WAIT_MP, then ISSUE + 39
      checks++;
      if (ack_t[2] != ack_t[1] + 3 + 39) begin
        errors++; $display("FAIL b2b_restart got %0d want %0d", ack_t[2] - ack_t[1], 42);
      end
      checks++;
      if (ack_d[0] !== 24'h080000 || ack_d[2] !== 24'h040000) begin
        errors++; $display("FAIL b2b_data got %h %h want 080000 040000", ack_d[0], ack_d[2]);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    int t;
    bit found;
    clear_mem();
    smp[0][0] = 24'h100000; smp[1][0] = 24'h100000;
    coef[0] = 16'h4000; coef[TAPS] = 16'h2000;
    apply_reset();
    do_frame(t);              // leaves phase = 1 and data_o nonzero
    clear_q();
    pulse_pop(t);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy_o && bank_addr[4:0] == 5'd10) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reach_tap10 got timeout want tap 10 in ISSUE");
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, ack_o, pop_o, overrun_o, data_o, ch_o, bank_addr, offset, mpcand, mplier} !== '0) begin
      errors++;
      $display("FAIL async_reset busy=%b ack=%b data=%h addr=%h cand=%h plier=%h want all 0",
               busy_o, ack_o, data_o, bank_addr, mpcand, mplier);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (ack_d.size() != 0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL no_ack_after_reset got acks=%0d busy=%b want 0 0", ack_d.size(), busy_o);
    end
    clear_q();
    do_frame(t);
    checks++;
    if (ack_d.size() != 2 || ack_d[0] !== 24'h080000 || ack_d[1] !== 24'h080000) begin
      errors++; $display("FAIL post_reset_frame got n=%0d data=%h want 2 x 080000", ack_d.size(), ack_d.size() > 0 ? ack_d[0] : 'x);
    end
  endtask

  initial begin
    clear_mem();
    for (int i = 0; i < MULT_LATENCY; i++) mp_pipe[i] = '0;
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_phase_pop();
    test_back_to_back();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
